// File: rtl/ucsbece154a_memcopy.sv
// DMA-style word copier for the single-port text/data memory.
// On an accepted start it moves len_i words from src_i to dst_i using
// alternating read and write bus cycles, two cycles per word.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start_i               copy request, only looked at while idle
//   src_i, dst_i, len_i   source/destination byte address, word count
//   busy_o                memory port owned (read or write cycle)
//   done_o, err_o         one-cycle completion / rejection pulses
//   count_o               words written in the current or last copy
//   a_o, we_o, wd_o       memory address, write enable, write data
//   rd_i                  memory read data, combinational from a_o
module ucsbece154a_memcopy #(
    parameter int unsigned TEXT_SIZE = 64,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [31:0]          src_i,
    input  logic [31:0]          dst_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] count_o,
    output logic [31:0]          a_o,
    output logic                 we_o,
    output logic [31:0]          wd_o,
    input  logic [31:0]          rd_i
);

    // Region bounds kept at 33 bits so a span end that carries out of
    // 32 bits lands above every limit and is rejected.
    localparam logic [32:0] TextBase = 33'h0_0001_0000;
    localparam logic [32:0] TextEnd  = TextBase + 33'(4 * TEXT_SIZE);
    localparam logic [32:0] DataBase = 33'h0_1000_0000;
    localparam logic [32:0] DataEnd  = DataBase + 33'(4 * DATA_SIZE);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

    state_e               state_q;
    logic [31:0]          src_ptr_q, dst_ptr_q;
    logic [LEN_WIDTH-1:0] rem_q;
    logic                 busy_q, done_q, err_q, we_q;
    logic [31:0]          a_q, wd_q;
    logic [LEN_WIDTH-1:0] count_q;

    logic [32:0] span, src_lo, dst_lo, src_hi, dst_hi;
    logic        misaligned, src_ok, dst_ok;

    always_comb begin
        span       = 33'({len_i, 2'b00});
        src_lo     = {1'b0, src_i};
        dst_lo     = {1'b0, dst_i};
        src_hi     = src_lo + span;
        dst_hi     = dst_lo + span;
        misaligned = (src_i[1:0] != 2'b00) || (dst_i[1:0] != 2'b00);
        src_ok     = ((src_lo >= TextBase) && (src_hi <= TextEnd)) ||
                     ((src_lo >= DataBase) && (src_hi <= DataEnd));
        dst_ok     = (dst_lo >= DataBase) && (dst_hi <= DataEnd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            wd_q      <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end else if (len_i == '0) begin
                            done_q  <= 1'b1;
                            count_q <= '0;
                            state_q <= StDone;
                        end else if (!src_ok || !dst_ok) begin
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end else begin
                            src_ptr_q <= src_i;
                            dst_ptr_q <= dst_i;
                            rem_q     <= len_i;
                            count_q   <= '0;
                            busy_q    <= 1'b1;
                            a_q       <= src_i;
                            state_q   <= StRead;
                        end
                    end
                end
                StRead: begin
                    // wd_q doubles as the word buffer for the write cycle.
                    wd_q    <= rd_i;
                    a_q     <= dst_ptr_q;
                    we_q    <= 1'b1;
                    state_q <= StWrite;
                end
                StWrite: begin
                    src_ptr_q <= src_ptr_q + 32'd4;
                    dst_ptr_q <= dst_ptr_q + 32'd4;
                    rem_q     <= rem_q - LEN_WIDTH'(1);
                    count_q   <= count_q + LEN_WIDTH'(1);
                    we_q      <= 1'b0;
                    wd_q      <= '0;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        busy_q  <= 1'b0;
                        a_q     <= '0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        a_q     <= src_ptr_q + 32'd4;
                        state_q <= StRead;
                    end
                end
                StDone, StErr: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    we_q    <= 1'b0;
                    a_q     <= '0;
                    wd_q    <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign we_o    = we_q;
    assign a_o     = a_q;
    assign wd_o    = wd_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_ucsbece154a_memcopy.sv
// Directed bench for ucsbece154a_memcopy with a behavioural text/data memory.
module tb_ucsbece154a_memcopy;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] src_i, dst_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, err_o, we_o;
    logic [15:0] count_o;
    logic [31:0] a_o, wd_o, rd_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] text_mem [64];
    logic [31:0] data_mem [64];
    logic        mem_init;
    int          stray_wr = 0;

    always #5 clk = ~clk;

    ucsbece154a_memcopy #(
        .TEXT_SIZE(64),
        .DATA_SIZE(64),
        .LEN_WIDTH(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .src_i  (src_i),
        .dst_i  (dst_i),
        .len_i  (len_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o),
        .count_o(count_o),
        .a_o    (a_o),
        .we_o   (we_o),
        .wd_o   (wd_o),
        .rd_i   (rd_i)
    );

    // Memory: TEXT at 0x00010000, DATA at 0x10000000, 64 words each.
    always_comb begin
        rd_i = 32'h0;
        if (a_o[31:8] == 24'h000100) rd_i = text_mem[a_o[7:2]];
        else if (a_o[31:8] == 24'h100000) rd_i = data_mem[a_o[7:2]];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                data_mem[i] <= (i < 8) ? 32'(i + 1) : 32'hDEAD_0000 + 32'(i);
        end else if (we_o) begin
            if (a_o[31:8] == 24'h100000) data_mem[a_o[7:2]] <= wd_o;
            else stray_wr <= stray_wr + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
    endtask

    // Issue one request and follow it to its done/err pulse; k=1 is cycle T+1.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       output int end_k, output logic was_done, output logic both,
                       output int wecnt, output logic busy_seen,
                       output logic [31:0] a1, output logic [31:0] a2,
                       output logic [31:0] wd2);
        src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
        step();
        start_i = 1'b0;
        end_k = -1; was_done = 1'b0; both = 1'b0; wecnt = 0; busy_seen = 1'b0;
        a1 = 'x; a2 = 'x; wd2 = 'x;
        for (int k = 1; k <= 200; k++) begin
            if (k == 1) a1 = a_o;
            if (k == 2) begin a2 = a_o; wd2 = wd_o; end
            if (we_o) wecnt++;
            if (busy_o) busy_seen = 1'b1;
            if (done_o || err_o) begin
                end_k = k; was_done = done_o; both = done_o && err_o;
                break;
            end
            step();
        end
        step();
    endtask

    int          end_k, wecnt, quiet;
    logic        was_done, both, busy_seen;
    logic [31:0] a1, a2, wd2;

    initial begin
        for (int i = 0; i < 64; i++) text_mem[i] = 32'hA000_0000 + 32'(i);
        reset = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0; mem_init = 1'b1;
        step();
        step();
        mem_init = 1'b0;
        reset = 1'b0;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_a", a_o, 32'h0);
        check("rst_wd", wd_o, 32'h0);
        check("rst_count", 32'(count_o), 32'd0);

        // 1: DATA[0..3] -> DATA[8..11]
        run(32'h1000_0000, 32'h1000_0020, 16'd4, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t1_end_cycle", 32'(end_k), 32'd9);
        check("t1_done", 32'(was_done), 32'd1);
        check("t1_we_cycles", 32'(wecnt), 32'd4);
        check("t1_count", 32'(count_o), 32'd4);
        check("t1_read_addr", a1, 32'h1000_0000);
        check("t1_write_addr", a2, 32'h1000_0020);
        check("t1_write_data", wd2, 32'd1);
        for (int i = 0; i < 4; i++) check("t1_dst_word", data_mem[8 + i], 32'(i + 1));
        check("t1_after_busy", 32'(busy_o), 32'd0);

        // 2: TEXT[0..1] -> DATA[0..1]
        run(32'h0001_0000, 32'h1000_0000, 16'd2, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t2_end_cycle", 32'(end_k), 32'd5);
        check("t2_done", 32'(was_done), 32'd1);
        check("t2_word0", data_mem[0], 32'hA000_0000);
        check("t2_word1", data_mem[1], 32'hA000_0001);

        // 3: misaligned source, then destination in TEXT
        run(32'h1000_0002, 32'h1000_0040, 16'd1, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t3a_end_cycle", 32'(end_k), 32'd1);
        check("t3a_err", 32'(was_done), 32'd0);
        check("t3a_no_we", 32'(wecnt), 32'd0);
        check("t3a_no_busy", 32'(busy_seen), 32'd0);
        run(32'h1000_0000, 32'h0001_0000, 16'd1, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t3b_end_cycle", 32'(end_k), 32'd1);
        check("t3b_err", 32'(was_done), 32'd0);
        check("t3b_not_both", 32'(both), 32'd0);
        check("t3b_no_we", 32'(wecnt), 32'd0);
        check("t3b_count_hold", 32'(count_o), 32'd2);

        // 4: destination span at the top of DATA
        init_mem();
        run(32'h1000_0000, 32'h1000_00FC, 16'd2, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t4a_end_cycle", 32'(end_k), 32'd1);
        check("t4a_err", 32'(was_done), 32'd0);
        check("t4a_no_we", 32'(wecnt), 32'd0);
        run(32'h1000_0000, 32'h1000_00FC, 16'd1, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t4b_end_cycle", 32'(end_k), 32'd3);
        check("t4b_done", 32'(was_done), 32'd1);
        check("t4b_last_word", data_mem[63], 32'd1);

        // 5: zero length
        run(32'h1000_0000, 32'h1000_0020, 16'd0, end_k, was_done, both, wecnt, busy_seen,
            a1, a2, wd2);
        check("t5_end_cycle", 32'(end_k), 32'd1);
        check("t5_done", 32'(was_done), 32'd1);
        check("t5_no_busy", 32'(busy_seen), 32'd0);
        check("t5_count", 32'(count_o), 32'd0);

        // 6: ignored start while busy, then reset during third write of len=5
        init_mem();
        src_i = 32'h1000_0000; dst_i = 32'h1000_0080; len_i = 16'd5; start_i = 1'b1;
        step();                                   // T+1
        start_i = 1'b0;
        check("t6_busy", 32'(busy_o), 32'd1);
        step();                                   // T+2
        len_i = 16'd0; dst_i = 32'h1000_0000; start_i = 1'b1;
        step();                                   // T+3
        start_i = 1'b0;
        check("t6_ignore_busy", 32'(busy_o), 32'd1);
        check("t6_ignore_done", 32'(done_o), 32'd0);
        check("t6_read1_addr", a_o, 32'h1000_0004);
        step();
        step();
        step();                                   // T+6: third write
        check("t6_third_we", 32'(we_o), 32'd1);
        check("t6_third_addr", a_o, 32'h1000_0088);
        check("t6_third_data", wd_o, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_we", 32'(we_o), 32'd0);
        check("t6_rst_a", a_o, 32'h0);
        check("t6_rst_wd", wd_o, 32'h0);
        check("t6_rst_count", 32'(count_o), 32'd0);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o || err_o || busy_o) quiet++;
            step();
        end
        check("t6_no_pulse", 32'(quiet), 32'd0);
        check("t6_word0", data_mem[32], 32'd1);
        check("t6_word1", data_mem[33], 32'd2);
        check("t6_word2", data_mem[34], 32'd3);
        check("t6_word3_untouched", data_mem[35], 32'hDEAD_0023);
        check("stray_writes", 32'(stray_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
